// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog
// Single-clock FIFO for any depth of 2 or more. The pointers wrap explicitly
// at FIFO_DEPTH-1, so the depth does not need to be a power of two.
// Almost-full and almost-empty thresholds are set at run time. The count
// output reports the current occupancy.
//
// Optional feature (macro FIFO_WATERMARK_EN): when the macro is defined, the
// block adds a peak-occupancy register (max_count) and a clear input (wm_clr).
// When it is undefined, both ports are absent and all other behaviour is
// unchanged.
//
// Handshake: a write is accepted on a rising edge when wr_en=1 and the
// registered full flag is 0. A read is accepted on a rising edge when rd_en=1
// and the registered empty flag is 0. Acceptance never looks at the opposite
// port in the same cycle, so a full FIFO rejects a write even while it is
// being read, and an empty FIFO rejects a read even while it is being written.
// wr_ack, overflow and underflow report the outcome of the previous edge for
// exactly one cycle. Read data appears on data_out one cycle after the
// accepted read.
module sync_fifo_prog #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [CNT_W-1:0]      af_level,
  input  logic [CNT_W-1:0]      ae_level,
`ifdef FIFO_WATERMARK_EN
  input  logic                  wm_clr,
  output logic [CNT_W-1:0]      max_count,
`endif
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int              PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_next;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_next;
  logic                  wr_acc;
  logic                  rd_acc;

  // Status flags come only from the registered count and the level inputs.
  // A threshold change therefore shows up in the same cycle.
  assign count       = count_q;
  assign full        = (count_q == CNT_FULL);
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= af_level) && !full;
  assign almostempty = (count_q <= ae_level) && !empty;

  // Acceptance decisions use the registered flags only.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Next pointer and occupancy values. Each pointer wraps at the last entry.
  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count_q;
    if (wr_acc) begin
      wr_ptr_next = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_next = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_q + 1'b1;
      2'b01:   count_next = count_q - 1'b1;
      default: count_next = count_q;
    endcase
  end

  // The storage array has no reset. Stale contents cannot be read because
  // the count and the pointers are reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointer, count and read-data registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      data_out <= '0;
    end else begin
      wr_ptr  <= wr_ptr_next;
      rd_ptr  <= rd_ptr_next;
      count_q <= count_next;
      if (rd_acc) begin
        data_out <= mem[rd_ptr];
      end
    end
  end

  // One-cycle status pulses that report the outcome of the previous edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_acc;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

`ifdef FIFO_WATERMARK_EN
  // Peak occupancy. The register tracks count_next, so it matches the count
  // that becomes visible after the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_count <= '0;
    end else if (wm_clr) begin
      max_count <= count_next;
    end else if (count_next > max_count) begin
      max_count <= count_next;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog
// Directed bench for sync_fifo_prog. It uses two instances: a depth-8 FIFO
// for the main scenarios and a depth-5 FIFO for the pointer-wrap scenario.
// Compile with +define+FIFO_WATERMARK_EN to include the watermark checks.
module tb_sync_fifo_prog;

  localparam int W   = 16;
  localparam int CW8 = 4;   // $clog2(9)
  localparam int CW5 = 3;   // $clog2(6)

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- depth-8 instance ----------------
  logic [W-1:0]   data_in, data_out;
  logic           wr_en, rd_en;
  logic [CW8-1:0] af_level, ae_level, count;
  logic           full, empty, almostfull, almostempty, wr_ack, overflow, underflow;
`ifdef FIFO_WATERMARK_EN
  logic           wm_clr;
  logic [CW8-1:0] max_count;
`endif

  sync_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .af_level(af_level), .ae_level(ae_level),
`ifdef FIFO_WATERMARK_EN
    .wm_clr(wm_clr), .max_count(max_count),
`endif
    .data_out(data_out), .count(count), .full(full), .empty(empty),
    .almostfull(almostfull), .almostempty(almostempty), .wr_ack(wr_ack),
    .overflow(overflow), .underflow(underflow)
  );

  // ---------------- depth-5 instance ----------------
  logic [W-1:0]   data_in5, data_out5;
  logic           wr_en5, rd_en5;
  logic [CW5-1:0] af_level5, ae_level5, count5;
  logic           full5, empty5, almostfull5, almostempty5, wr_ack5, overflow5, underflow5;
`ifdef FIFO_WATERMARK_EN
  logic           wm_clr5;
  logic [CW5-1:0] max_count5;
`endif

  sync_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in5), .wr_en(wr_en5), .rd_en(rd_en5),
    .af_level(af_level5), .ae_level(ae_level5),
`ifdef FIFO_WATERMARK_EN
    .wm_clr(wm_clr5), .max_count(max_count5),
`endif
    .data_out(data_out5), .count(count5), .full(full5), .empty(empty5),
    .almostfull(almostfull5), .almostempty(almostempty5), .wr_ack(wr_ack5),
    .overflow(overflow5), .underflow(underflow5)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge. Outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push8(input logic [W-1:0] d);
    wr_en = 1'b1; rd_en = 1'b0; data_in = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop8();
    rd_en = 1'b1; wr_en = 1'b0;
    tick();
    rd_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] e;
    rst_n = 1'b0;
    data_in = '0; wr_en = 1'b0; rd_en = 1'b0; af_level = 4'd6; ae_level = 4'd2;
    data_in5 = '0; wr_en5 = 1'b0; rd_en5 = 1'b0; af_level5 = 3'd4; ae_level5 = 3'd1;
`ifdef FIFO_WATERMARK_EN
    wm_clr = 1'b0; wm_clr5 = 1'b0;
`endif
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset state, then idle.
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_data",  32'(data_out), 32'd0);
    check("rst_full",  32'(full), 32'd0);
    check("rst_af",    32'(almostfull), 32'd0);
    check("rst_ae",    32'(almostempty), 32'd0);
    check("rst_flags", 32'({wr_ack, overflow, underflow}), 32'd0);
    check("rst_empty5", 32'(empty5), 32'd1);

    // Fill 1..8 with af=6 and ae=2.
    for (int i = 1; i <= 8; i++) begin
      push8(W'(i));
      check("fill_count", 32'(count), 32'(i));
      check("fill_ack",   32'(wr_ack), 32'd1);
      check("fill_ae",    32'(almostempty), 32'((i <= 2) ? 1 : 0));
      check("fill_af",    32'(almostfull), 32'((i >= 6 && i < 8) ? 1 : 0));
      check("fill_full",  32'(full), 32'((i == 8) ? 1 : 0));
    end
    // A ninth write into a full FIFO.
    push8(16'h0009);
    check("ovf_flag",  32'(overflow), 32'd1);
    check("ovf_ack",   32'(wr_ack), 32'd0);
    check("ovf_count", 32'(count), 32'd8);

    // Drain 8 words in order.
    for (int i = 1; i <= 8; i++) begin
      pop8();
      check("drain_data",  32'(data_out), 32'(i));
      check("drain_count", 32'(count), 32'(8 - i));
      if (i == 1) check("ovf_oneshot", 32'(overflow), 32'd0);
    end
    pop8();
    check("udf_flag", 32'(underflow), 32'd1);
    check("udf_hold", 32'(data_out), 32'd8);
    tick();
    check("udf_oneshot", 32'(underflow), 32'd0);

    // Simultaneous read and write at count 4.
    for (int i = 0; i < 4; i++) push8(W'(16'h0011 + i));
    wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h0015;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("rw4_count", 32'(count), 32'd4);
    check("rw4_ack",   32'(wr_ack), 32'd1);
    check("rw4_data",  32'(data_out), 32'h11);
    for (int i = 0; i < 4; i++) begin
      pop8();
      check("rw4_drain", 32'(data_out), 32'(16'h0012 + i));
    end
    check("rw4_empty", 32'(empty), 32'd1);

    // Simultaneous read and write at count 0: only the write is accepted.
    wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h0020;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("rw0_count", 32'(count), 32'd1);
    check("rw0_udf",   32'(underflow), 32'd1);
    check("rw0_ack",   32'(wr_ack), 32'd1);
    check("rw0_hold",  32'(data_out), 32'h15);

    // A threshold change takes effect with no pipeline delay (count is 1).
    check("thr_ae_on", 32'(almostempty), 32'd1);
    ae_level = 4'd0;
    #1;
    check("thr_ae_off", 32'(almostempty), 32'd0);
    af_level = 4'd1;
    #1;
    check("thr_af_on", 32'(almostfull), 32'd1);
    af_level = 4'd6; ae_level = 4'd2;
    pop8();
    check("rw0_data", 32'(data_out), 32'h20);

`ifdef FIFO_WATERMARK_EN
    // Watermark: clear at 0, fill to 7, drain to 2, clear again.
    wm_clr = 1'b1; tick(); wm_clr = 1'b0;
    check("wm_clr0", 32'(max_count), 32'd0);
    for (int i = 0; i < 7; i++) push8(W'(16'h0040 + i));
    for (int i = 0; i < 5; i++) pop8();
    check("wm_count2", 32'(count), 32'd2);
    check("wm_peak7",  32'(max_count), 32'd7);
    wm_clr = 1'b1; tick(); wm_clr = 1'b0;
    check("wm_clr2", 32'(max_count), 32'd2);
`endif

    // Reset mid-stream while requests are active.
    for (int i = 0; i < 3; i++) push8(W'(16'h0050 + i));
    rst_n = 1'b0; wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h00ff;
    tick();
    rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    check("mrst_count", 32'(count), 32'd0);
    check("mrst_empty", 32'(empty), 32'd1);
    check("mrst_flags", 32'({wr_ack, overflow, underflow}), 32'd0);
    check("mrst_data",  32'(data_out), 32'd0);
`ifdef FIFO_WATERMARK_EN
    check("mrst_wm", 32'(max_count), 32'd0);
`endif
    pop8();
    check("mrst_udf", 32'(underflow), 32'd1);

    // Depth 5: prefill 2 words, then 12 write/read pairs across the wrap.
    for (int i = 0; i < 2; i++) begin
      wr_en5 = 1'b1; data_in5 = W'(16'h0100 + i); exp_q.push_back(data_in5);
      tick();
    end
    for (int k = 0; k < 12; k++) begin
      wr_en5 = 1'b1; rd_en5 = 1'b1; data_in5 = W'(16'h0102 + k);
      exp_q.push_back(data_in5);
      tick();
      e = exp_q.pop_front();
      check("d5_data",  32'(data_out5), 32'(e));
      check("d5_count", 32'(count5), 32'd2);
      check("d5_flags", 32'({overflow5, underflow5, full5, empty5, almostfull5, almostempty5}), 32'd0);
    end
    wr_en5 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      check("d5_tail", 32'(data_out5), 32'(e));
    end
    rd_en5 = 1'b0;
    tick();
    check("d5_empty", 32'(empty5), 32'd1);
    // Fill depth-5 to full, then write once more.
    wr_en5 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in5 = W'(16'h0200 + i);
      tick();
    end
    check("d5_full",  32'(full5), 32'd1);
    check("d5_cnt5",  32'(count5), 32'd5);
    tick();
    wr_en5 = 1'b0;
    check("d5_ovf",   32'(overflow5), 32'd1);
    rd_en5 = 1'b1;
    tick();
    rd_en5 = 1'b0;
    check("d5_first", 32'(data_out5), 32'h200);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Parametrised synchronous FIFO with programmable almost-full/almost-empty thresholds, an occupancy count output and support for any depth of 2 or more (not restricted to powers of two). It replaces the fixed-threshold FIFO in the datapath: write side and read side share one clock. It keeps the existing status set (full, empty, almostfull, almostempty, wr_ack, overflow, underflow) so current benches and monitors carry over, and adds run-time threshold control and an optional peak-occupancy watermark.

## Interface
- FIFO_WIDTH, 16, data word width in bits (≥1)
- FIFO_DEPTH, 8, number of entries (≥2, any integer)
- CNT_W, $clog2(FIFO_DEPTH+1), derived; width of count and threshold ports
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset: synchronous, active-low; one clock, sampled on rising edge of clk
- data_in  in  FIFO_WIDTH  write data
- wr_en  in  1  write request
- rd_en  in  1  read request
- af_level  in  CNT_W  almost-full threshold (quasi-static)
- ae_level  in  CNT_W  almost-empty threshold (quasi-static)
- data_out  out  FIFO_WIDTH  registered read data
- count  out  CNT_W  current occupancy, 0..FIFO_DEPTH
- full, empty, almostfull, almostempty  out  1  status flags
- wr_ack  out  1  registered: previous-cycle write accepted
- overflow  out  1  registered: previous-cycle write rejected (full)
- underflow  out  1  registered: previous-cycle read rejected (empty)
- wm_clr  in  1  watermark clear (only with FIFO_WATERMARK_EN)
- max_count  out  CNT_W  peak occupancy (only with FIFO_WATERMARK_EN)

## Operation
- Storage: FIFO_DEPTH × FIFO_WIDTH array; wr_ptr, rd_ptr in 0..FIFO_DEPTH-1; each wraps FIFO_DEPTH-1 → 0 on increment.
- Write accepted iff wr_en && !full: mem[wr_ptr] ← data_in, wr_ptr advances.
- Read accepted iff rd_en && !empty: data_out ← mem[rd_ptr], rd_ptr advances. No accepted read: data_out holds.
- Acceptance uses registered full/empty only. A write is rejected when full even if a read is accepted in the same cycle. A read is rejected when empty even if a write is accepted in the same cycle.
- count_next = count + wr_acc − rd_acc. Both accepted → count unchanged.
- Flags (combinational from registered count and level inputs):
  - full = (count == FIFO_DEPTH); empty = (count == 0)
  - almostfull = (count ≥ af_level) && !full
  - almostempty = (count ≤ ae_level) && !empty
  - af_level = 0 or > FIFO_DEPTH−1 gives degenerate but defined behaviour per the equations.
- wr_ack ← wr_acc; overflow ← wr_en && full; underflow ← rd_en && empty. Each flag lasts exactly one cycle per event.
- Reset (rst_n low at edge): pointers=0, count=0, data_out=0, wr_ack=0, overflow=0, underflow=0. Hence empty=1, full=0, almostfull=0, almostempty=0. Memory contents are not cleared. Reset overrides any simultaneous wr_en/rd_en. Reset in mid-stream discards all stored data.

## Timing
- Write to visible: data written at edge N is readable by a read accepted at edge N+1 or later. count and flags update after edge N.
- Read latency: data_out valid one cycle after the accepted read edge.
- wr_ack/overflow/underflow assert the cycle after the triggering edge.
- Threshold changes affect almostfull/almostempty combinationally, with no pipeline.

## Configuration
- FIFO_WATERMARK_EN defined: max_count register and wm_clr port exist.
  - Reset sets max_count=0.
  - wm_clr high sets max_count ← count_next.
  - Otherwise max_count ← max(max_count, count_next).
  - Priority: rst_n > wm_clr.
- Not defined: max_count and wm_clr are absent from the port list. All other behaviour is identical.

## Test plan
- Reset then idle, FIFO_DEPTH=8: empty=1, count=0, data_out=0, all other flags 0.
- Write 0x0001..0x0008: count reaches 8 and full=1. A 9th write gives overflow=1, wr_ack=0, count stays 8. Read 8 words: data_out 0x0001..0x0008 in order, each one cycle after its read. A 9th read gives underflow=1.
- af_level=6, ae_level=2, fill from empty: almostempty=1 at count 1–2. almostfull=1 at count 6–7 and drops at 8 (full=1).
- Simultaneous wr_en+rd_en at count=4: count stays 4, wr_ack=1, data_out = oldest word. At count=0: only the write is accepted, underflow=1, count becomes 1.
- FIFO_DEPTH=5: 12 write/read pairs; pointers wrap 4→0; data order preserved, no spurious flags.
- FIFO_WATERMARK_EN: fill to 7, drain to 2 → max_count=7. Pulse wm_clr at count 2 → max_count=2. Assert rst_n low mid-stream → count=0, max_count=0, empty=1.
